// File: rtl/dmem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_lsu
//  Purpose  : Load/store initiator for the 16-bit data memory. Accepts byte
//             and halfword requests over valid/ready, runs read/write cycles
//             (byte stores as read-modify-write) and returns one response
//             per request with sign/zero-extended load data.
//  Options  : DMEM_LSU_STATS_EN adds saturating load/store/error counters.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_lsu #(
   parameter int AW = 16,
   parameter int DW = 16
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic          req_we_i,
   input  logic          req_size_i,
   input  logic          req_unsigned_i,
   input  logic [AW-1:0] req_addr_i,
   input  logic [DW-1:0] req_wdata_i,
   output logic          resp_valid_o,
   output logic [DW-1:0] resp_rdata_o,
   output logic          resp_err_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_wdata_o,
   output logic          mem_write_o,
   output logic          mem_read_o,
   input  logic [DW-1:0] mem_rdata_i
`ifdef DMEM_LSU_STATS_EN
   ,
   output logic [15:0]   stat_loads_o,
   output logic [15:0]   stat_stores_o,
   output logic [15:0]   stat_errs_o
`endif
);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_RD   = 3'd1,
      S_CAP  = 3'd2,
      S_WR   = 3'd3,
      S_RESP = 3'd4
   } state_t;

   state_t        r_state, w_state_nxt;

   // Latched request fields; halfword store data is consumed on accept,
   // so only the low byte of the store data needs to be kept.
   logic          r_we, r_size, r_uns, r_lane;
   logic [7:0]    r_wbyte;

   // Output registers and their next values
   logic          r_resp_valid, w_resp_valid_nxt;
   logic [DW-1:0] r_resp_rdata, w_resp_rdata_nxt;
   logic          r_resp_err,   w_resp_err_nxt;
   logic [AW-1:0] r_mem_addr,   w_mem_addr_nxt;
   logic [DW-1:0] r_mem_wdata,  w_mem_wdata_nxt;
   logic          r_mem_write,  w_mem_write_nxt;
   logic          r_mem_read,   w_mem_read_nxt;

   logic          w_accept;
   logic [7:0]    w_lane_byte;

   assign req_ready_o  = (r_state == S_IDLE);
   assign w_accept     = req_valid_i && req_ready_o;
   assign w_lane_byte  = r_lane ? mem_rdata_i[15:8] : mem_rdata_i[7:0];

   assign resp_valid_o = r_resp_valid;
   assign resp_rdata_o = r_resp_rdata;
   assign resp_err_o   = r_resp_err;
   assign mem_addr_o   = r_mem_addr;
   assign mem_wdata_o  = r_mem_wdata;
   assign mem_write_o  = r_mem_write;
   assign mem_read_o   = r_mem_read;

   // Next-state and next-output decode; outputs are registered so each value
   // computed here appears during the state it is entering.
   always_comb begin
      w_state_nxt      = r_state;
      w_resp_valid_nxt = 1'b0;
      w_resp_rdata_nxt = '0;
      w_resp_err_nxt   = 1'b0;
      w_mem_addr_nxt   = r_mem_addr;
      w_mem_wdata_nxt  = '0;
      w_mem_write_nxt  = 1'b0;
      w_mem_read_nxt   = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               if (req_size_i && req_addr_i[0]) begin
                  w_state_nxt      = S_RESP;
                  w_resp_valid_nxt = 1'b1;
                  w_resp_err_nxt   = 1'b1;
               end else if (req_size_i && req_we_i) begin
                  w_state_nxt     = S_WR;
                  w_mem_write_nxt = 1'b1;
                  w_mem_addr_nxt  = {req_addr_i[AW-1:1], 1'b0};
                  w_mem_wdata_nxt = req_wdata_i;
               end else begin
                  w_state_nxt    = S_RD;
                  w_mem_read_nxt = 1'b1;
                  w_mem_addr_nxt = {req_addr_i[AW-1:1], 1'b0};
               end
            end
         end
         S_RD: begin
            w_state_nxt = S_CAP;
         end
         S_CAP: begin
            if (r_we) begin
               // Byte store merge: replace only the addressed lane
               w_state_nxt     = S_WR;
               w_mem_write_nxt = 1'b1;
               w_mem_wdata_nxt = r_lane ? {r_wbyte, mem_rdata_i[7:0]}
                                        : {mem_rdata_i[15:8], r_wbyte};
            end else begin
               w_state_nxt      = S_RESP;
               w_resp_valid_nxt = 1'b1;
               if (r_size) begin
                  w_resp_rdata_nxt = mem_rdata_i;
               end else if (r_uns) begin
                  w_resp_rdata_nxt = {{(DW-8){1'b0}}, w_lane_byte};
               end else begin
                  w_resp_rdata_nxt = {{(DW-8){w_lane_byte[7]}}, w_lane_byte};
               end
            end
         end
         S_WR: begin
            w_state_nxt      = S_RESP;
            w_resp_valid_nxt = 1'b1;
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // State, output and request-latch registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_we         <= 1'b0;
         r_size       <= 1'b0;
         r_uns        <= 1'b0;
         r_lane       <= 1'b0;
         r_wbyte      <= '0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_resp_err   <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_write  <= 1'b0;
         r_mem_read   <= 1'b0;
      end else begin
         r_state      <= w_state_nxt;
         r_resp_valid <= w_resp_valid_nxt;
         r_resp_rdata <= w_resp_rdata_nxt;
         r_resp_err   <= w_resp_err_nxt;
         r_mem_addr   <= w_mem_addr_nxt;
         r_mem_wdata  <= w_mem_wdata_nxt;
         r_mem_write  <= w_mem_write_nxt;
         r_mem_read   <= w_mem_read_nxt;
         if (w_accept) begin
            r_we    <= req_we_i;
            r_size  <= req_size_i;
            r_uns   <= req_unsigned_i;
            r_lane  <= req_addr_i[0];
            r_wbyte <= req_wdata_i[7:0];
         end
      end
   end

`ifdef DMEM_LSU_STATS_EN
   logic [15:0] r_stat_loads, r_stat_stores, r_stat_errs;

   assign stat_loads_o  = r_stat_loads;
   assign stat_stores_o = r_stat_stores;
   assign stat_errs_o   = r_stat_errs;

   // Saturating per-class counters, bumped once on the response cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stat_loads  <= '0;
         r_stat_stores <= '0;
         r_stat_errs   <= '0;
      end else if (r_state == S_RESP) begin
         if (r_resp_err) begin
            if (r_stat_errs != 16'hFFFF) r_stat_errs <= r_stat_errs + 16'd1;
         end else if (r_we) begin
            if (r_stat_stores != 16'hFFFF) r_stat_stores <= r_stat_stores + 16'd1;
         end else begin
            if (r_stat_loads != 16'hFFFF) r_stat_loads <= r_stat_loads + 16'd1;
         end
      end
   end
`endif

endmodule
`default_nettype wire
